// File: rtl/forth_exec_unit.sv
// Execute stage feeding the Forth data stack.
// Ports: Clk/Rst; Start/Op/Imm/T/N issue; Busy/Done; TWrite/NWrite/WData/Offset.
module forth_exec_unit #(
  parameter int W    = 16,
  parameter int ITER = 16
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         Start,
  input  logic [3:0]   Op,
  input  logic [W-1:0] Imm,
  input  logic [W-1:0] T,
  input  logic [W-1:0] N,
  output logic         Busy,
  output logic         Done,
  output logic         TWrite,
  output logic         NWrite,
  output logic [W-1:0] WData,
  output logic [1:0]   Offset
);

  typedef enum logic [2:0] {
    IDLE, COMMIT, SWP2, MUL, DIV, DIV2
  } state_t;

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  localparam logic [1:0] OFF_Z = 2'b00;
  localparam logic [1:0] OFF_P = 2'b01;
  localparam logic [1:0] OFF_M = 2'b11;

  state_t        state;
  logic [W-1:0]  t0;
  logic [W-1:0]  x;
  logic [W-1:0]  y;
  logic [W-1:0]  acc;
  logic [CW-1:0] cnt;

  // mul: x = shifted multiplicand, y = multiplier, acc = product
  // div: x = divisor, y = dividend/quotient, acc = remainder
  logic [W-1:0] mul_acc;
  logic [W:0]   div_sh;
  logic         div_ge;
  logic [W-1:0] div_dif;
  logic [W-1:0] div_rem;
  logic [W-1:0] div_quo;

  always_comb begin
    mul_acc = acc + (y[0] ? x : '0);
    div_sh  = {acc, y[W-1]};
    div_ge  = div_sh >= {1'b0, x};
    // true difference is < divisor, so W bits suffice
    div_dif = div_sh[W-1:0] - x;
    div_rem = div_ge ? div_dif : div_sh[W-1:0];
    div_quo = {y[W-2:0], div_ge};
  end

  logic         sc_we;
  logic [W-1:0] sc_data;
  logic [1:0]   sc_off;

  always_comb begin
    sc_we   = 1'b0;
    sc_data = '0;
    sc_off  = OFF_Z;
    unique case (Op)
      4'd1:  begin sc_we = 1'b1; sc_data = N + T;   sc_off = OFF_M; end
      4'd2:  begin sc_we = 1'b1; sc_data = N - T;   sc_off = OFF_M; end
      4'd3:  begin sc_we = 1'b1; sc_data = N & T;   sc_off = OFF_M; end
      4'd4:  begin sc_we = 1'b1; sc_data = N | T;   sc_off = OFF_M; end
      4'd5:  begin sc_we = 1'b1; sc_data = N ^ T;   sc_off = OFF_M; end
      4'd6:  begin sc_we = 1'b1; sc_data = ~T;                      end
      4'd7:  begin sc_we = 1'b1; sc_data = T;       sc_off = OFF_P; end
      4'd8:  begin                                  sc_off = OFF_M; end
      4'd10: begin sc_we = 1'b1; sc_data = N;       sc_off = OFF_P; end
      4'd11: begin sc_we = 1'b1; sc_data = Imm;     sc_off = OFF_P; end
      4'd14: begin sc_we = 1'b1; sc_data = T << 1;                  end
      4'd15: begin sc_we = 1'b1; sc_data = T >> 1;                  end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state  <= IDLE;
      Busy   <= 1'b0;
      Done   <= 1'b0;
      TWrite <= 1'b0;
      NWrite <= 1'b0;
      WData  <= '0;
      Offset <= OFF_Z;
      t0     <= '0;
      x      <= '0;
      y      <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      // every output pulse lasts exactly one cycle
      Done   <= 1'b0;
      TWrite <= 1'b0;
      NWrite <= 1'b0;
      WData  <= '0;
      Offset <= OFF_Z;
      case (state)
        IDLE: if (Start) begin
          Busy <= 1'b1;
          t0   <= T;
          cnt  <= '0;
          acc  <= '0;
          case (Op)
            4'd9: begin
              TWrite <= 1'b1;
              WData  <= N;
              state  <= SWP2;
            end
            4'd12: begin
              x     <= N;
              y     <= T;
              state <= MUL;
            end
            4'd13: begin
              x     <= T;
              y     <= N;
              state <= DIV;
            end
            default: begin
              TWrite <= sc_we;
              WData  <= sc_data;
              Offset <= sc_off;
              Done   <= 1'b1;
              state  <= COMMIT;
            end
          endcase
        end
        SWP2: begin
          NWrite <= 1'b1;
          WData  <= t0;
          Done   <= 1'b1;
          state  <= COMMIT;
        end
        MUL: begin
          acc <= mul_acc;
          x   <= x << 1;
          y   <= y >> 1;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            TWrite <= 1'b1;
            WData  <= mul_acc;
            Offset <= OFF_M;
            Done   <= 1'b1;
            state  <= COMMIT;
          end
        end
        DIV: begin
          acc <= div_rem;
          y   <= div_quo;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            TWrite <= 1'b1;
            WData  <= div_quo;
            state  <= DIV2;
          end
        end
        DIV2: begin
          NWrite <= 1'b1;
          WData  <= acc;
          Done   <= 1'b1;
          state  <= COMMIT;
        end
        COMMIT: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
